// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: spi_if word/config field positions,
// FSM state encodings and the latched access kind.
package spi_arbiter_pkg;

    localparam int WORD_W  = 11;
    localparam int RDATA_W = 9;

    localparam int DATA_LSB      = 0;
    localparam int DATA_MSB      = 7;
    localparam int START_BIT     = 8;
    localparam int STOP_BIT      = 9;
    localparam int RX_BIT        = 10;
    localparam int CFG_MODE_LSB  = 0;
    localparam int CFG_MODE_MSB  = 1;
    localparam int CFG_LSB_BIT   = 2;
    localparam int CFG_BAUD_LSB  = 3;
    localparam int CFG_BAUD_MSB  = 10;
    localparam int RD_EMPTY_BIT  = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CFG   = 3'd1;
    localparam logic [2:0] ST_CFG_W = 3'd2;
    localparam logic [2:0] ST_GRANT = 3'd3;
    localparam logic [2:0] ST_ACC   = 3'd4;
    localparam logic [2:0] ST_ACC_W = 3'd5;

    typedef enum logic [1:0] {
        ACC_CMD = 2'd0,
        ACC_WR  = 2'd1,
        ACC_RD  = 2'd2
    } acc_kind_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 with wrap.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int GW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [GW-1:0]   gnt_idx,
    output logic            found
);

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int d = 0; d < NREQ; d++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + 1 + d) % NREQ) == i)) begin
                    found     = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = GW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_if between NREQ requesters: loads the winner's private config word on
// grant, then forwards its cmd/wr/rd strobes one at a time until it releases.
module spi_arbiter
    import spi_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int GW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          rq_req,
    input  logic [NREQ*WORD_W-1:0]   rq_din,
    input  logic [NREQ-1:0]          rq_cmd,
    input  logic [NREQ-1:0]          rq_wr,
    input  logic [NREQ-1:0]          rq_rd,
    output logic [RDATA_W-1:0]       rq_dout,
    output logic [NREQ-1:0]          rq_ack,
    output logic [NREQ-1:0]          rq_gnt,
    output logic [WORD_W-1:0]        spi_din,
    output logic                     spi_cmd,
    output logic                     spi_wr,
    output logic                     spi_rd,
    input  logic [RDATA_W-1:0]       spi_dout,
    input  logic                     spi_ack
);

    logic [2:0]      state;
    logic [GW-1:0]   ptr;
    word_t           cfg [NREQ];
    acc_kind_t       kind;
    word_t           word;

    logic [NREQ-1:0] pick_oh;
    logic [GW-1:0]   pick_idx;
    logic            pick_found;
    logic [NREQ-1:0] local_ack;
    word_t           cfg_g;
    word_t           din_g;
    logic            g_req;
    logic            g_cmd;
    logic            g_wr;
    logic            g_rd;

    rr_picker #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_picker (
        .req     (rq_req),
        .ptr     (ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .found   (pick_found)
    );

    // rq_gnt is one-hot, so it doubles as the select for the granted requester's fields.
    always_comb begin
        cfg_g = '0;
        din_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rq_gnt[i]) begin
                cfg_g = cfg[i];
                din_g = rq_din[WORD_W*i +: WORD_W];
            end
        end
    end

    // A strobe in its own ack cycle is the tail of the previous access, never a new one.
    assign local_ack = rq_cmd & ~rq_gnt & ~rq_ack;
    assign g_req     = |(rq_req & rq_gnt);
    assign g_cmd     = |(rq_cmd & rq_gnt & ~rq_ack);
    assign g_wr      = |(rq_wr  & rq_gnt & ~rq_ack);
    assign g_rd      = |(rq_rd  & rq_gnt & ~rq_ack);

    always_comb begin
        spi_cmd = 1'b0;
        spi_wr  = 1'b0;
        spi_rd  = 1'b0;
        spi_din = '0;
        if (state == ST_CFG) begin
            spi_cmd = 1'b1;
            spi_din = cfg_g;
        end else if (state == ST_ACC) begin
            spi_cmd = (kind == ACC_CMD);
            spi_wr  = (kind == ACC_WR);
            spi_rd  = (kind == ACC_RD);
            spi_din = word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= GW'(NREQ - 1);
            rq_gnt  <= '0;
            rq_ack  <= '0;
            rq_dout <= '0;
            kind    <= ACC_CMD;
            word    <= '0;
            for (int i = 0; i < NREQ; i++) begin
                cfg[i] <= '0;
            end
        end else begin
            rq_ack <= local_ack | (((state == ST_ACC_W) && spi_ack) ? rq_gnt : '0);

            for (int i = 0; i < NREQ; i++) begin
                if (local_ack[i]) begin
                    cfg[i] <= rq_din[WORD_W*i +: WORD_W];
                end else if ((state == ST_ACC) && (kind == ACC_CMD) && rq_gnt[i]) begin
                    cfg[i] <= word;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        ptr    <= pick_idx;
                        rq_gnt <= pick_oh;
                        state  <= ST_CFG;
                    end
                end
                ST_CFG: begin
                    state <= ST_CFG_W;
                end
                ST_CFG_W: begin
                    state <= spi_ack ? ST_GRANT : ST_CFG;
                end
                ST_GRANT: begin
                    if (g_cmd) begin
                        kind  <= ACC_CMD;
                        word  <= din_g;
                        state <= ST_ACC;
                    end else if (g_wr) begin
                        kind  <= ACC_WR;
                        word  <= din_g;
                        state <= ST_ACC;
                    end else if (g_rd) begin
                        kind  <= ACC_RD;
                        word  <= din_g;
                        state <= ST_ACC;
                    end else if (!g_req) begin
                        rq_gnt <= '0;
                        state  <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    state <= ST_ACC_W;
                end
                ST_ACC_W: begin
                    // No ack means spi_if refused the strobe (tx FIFO full): re-issue it.
                    if (spi_ack) begin
                        if (kind == ACC_RD) begin
                            rq_dout <= spi_dout;
                        end
                        state <= ST_GRANT;
                    end else begin
                        state <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
